// File: rtl/ibtb_gh_tracker_pkg.sv
// Shared types, sizes and the history shift function for the IBTB global-history tracker.
package ibtb_gh_tracker_pkg;

  localparam int IBTB_GH_BITS          = 8;
  localparam int IBTB_GH_CHKPT_ENTRIES = 8;
  localparam int IBTB_GH_SHIFT_BITS    = 2;
  localparam int IBTB_GH_IDX_BITS      = $clog2(IBTB_GH_CHKPT_ENTRIES);

  typedef logic [IBTB_GH_BITS-1:0]     ibtb_gh_t;
  typedef logic [IBTB_GH_IDX_BITS-1:0] ibtb_gh_chkpt_idx_t;
  // Ring pointer: checkpoint index plus one wrap bit to tell full from empty.
  typedef logic [IBTB_GH_IDX_BITS:0]   ibtb_gh_ptr_t;
  typedef logic [37:0]                 pc38_t;

  // Age the history by SHIFT_BITS and append the low target bits as the newest part.
  function automatic ibtb_gh_t ibtb_gh_next(ibtb_gh_t gh, pc38_t tgt);
    return {gh[IBTB_GH_BITS-1-IBTB_GH_SHIFT_BITS:0], tgt[IBTB_GH_SHIFT_BITS-1:0]};
  endfunction

endpackage

// File: rtl/ibtb_gh_tracker_if.sv
// Predict / commit / restore signal bundle between the frontend and the GH tracker.
interface ibtb_gh_tracker_if;
  import ibtb_gh_tracker_pkg::*;

  logic               predict_valid;
  pc38_t              predict_tgt_pc38;
  logic               predict_ready;
  ibtb_gh_chkpt_idx_t predict_chkpt_idx;
  ibtb_gh_t           read_ibtb_gh;
  logic               commit_valid;
  ibtb_gh_t           commit_ibtb_gh;
  logic               restore_valid;
  ibtb_gh_chkpt_idx_t restore_chkpt_idx;
  pc38_t              restore_tgt_pc38;
  logic               empty;

  // Frontend / backend side that drives predictions, retirements and mispredicts.
  modport master (
    output predict_valid, predict_tgt_pc38, commit_valid,
           restore_valid, restore_chkpt_idx, restore_tgt_pc38,
    input  predict_ready, predict_chkpt_idx, read_ibtb_gh, commit_ibtb_gh, empty
  );

  // Tracker side that owns the speculative history and checkpoint ring.
  modport slave (
    input  predict_valid, predict_tgt_pc38, commit_valid,
           restore_valid, restore_chkpt_idx, restore_tgt_pc38,
    output predict_ready, predict_chkpt_idx, read_ibtb_gh, commit_ibtb_gh, empty
  );

endinterface

// File: rtl/ibtb_gh_tracker.sv
// Speculative indirect-branch global history with an in-order checkpoint ring.
// Predictions push the pre-shift history, commits retire from the head, and a
// mispredict rebuilds history from its checkpoint and drops everything younger.
module ibtb_gh_tracker
  import ibtb_gh_tracker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  ibtb_gh_tracker_if.slave    bus
);

  localparam int IDX_W = IBTB_GH_IDX_BITS;

  ibtb_gh_t           gh_q, gh_d;
  ibtb_gh_ptr_t       head_q, head_d;
  ibtb_gh_ptr_t       tail_q, tail_d;
  ibtb_gh_t           chkpt_q [IBTB_GH_CHKPT_ENTRIES];

  logic               full;
  logic               is_empty;
  logic               push_fire;
  logic               commit_fire;
  ibtb_gh_ptr_t       restore_pos;
  ibtb_gh_ptr_t       inflight_cnt;
  ibtb_gh_ptr_t       restore_off;
  ibtb_gh_chkpt_idx_t head_idx;
  ibtb_gh_chkpt_idx_t tail_idx;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Ring status and handshake qualification, all from registered pointers (no commit bypass).
  always_comb begin
    is_empty    = (head_q == tail_q);
    full        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    push_fire   = bus.predict_valid && !full && !bus.restore_valid;
    commit_fire = bus.commit_valid && !is_empty;
  end

  // Next-state math: restore beats push; commit advances head independently of both.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    gh_d         = gh_q;
    // A restored index at or above head's index sits in head's lap, otherwise in the next lap,
    // which keeps the restored entry inside [head, head+C).
    restore_pos  = {(bus.restore_chkpt_idx >= head_idx) ? head_q[IDX_W] : ~head_q[IDX_W],
                    bus.restore_chkpt_idx};
    inflight_cnt = tail_q - head_q;
    restore_off  = restore_pos - head_q;
    if (commit_fire) begin
      head_d = head_q + ibtb_gh_ptr_t'(1);
    end
    if (bus.restore_valid) begin
      gh_d   = ibtb_gh_next(chkpt_q[bus.restore_chkpt_idx], bus.restore_tgt_pc38);
      tail_d = restore_pos + ibtb_gh_ptr_t'(1);
    end else if (push_fire) begin
      gh_d   = ibtb_gh_next(gh_q, bus.predict_tgt_pc38);
      tail_d = tail_q + ibtb_gh_ptr_t'(1);
    end
  end

  // History and ring pointers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gh_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      gh_q   <= gh_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Checkpoint storage: a pushed branch records the history it was predicted with.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      chkpt_q[tail_idx] <= gh_q;
    end
  end

  assign bus.predict_ready     = !full;
  assign bus.predict_chkpt_idx = tail_idx;
  assign bus.read_ibtb_gh      = gh_q;
  assign bus.commit_ibtb_gh    = chkpt_q[head_idx];
  assign bus.empty             = is_empty;

  // Retiring with nothing in flight is a protocol error from the backend.
  a_commit_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
    bus.commit_valid |-> !is_empty);

  // A mispredict must name a checkpoint that is still in flight.
  a_restore_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    bus.restore_valid |-> (restore_off < inflight_cnt));

endmodule

// File: tb/tb_ibtb_gh_tracker.sv
// Self-checking bench for ibtb_gh_tracker: directed scenarios followed by random
// predict/commit/restore traffic against a queue-based reference model.
module tb_ibtb_gh_tracker;
  import ibtb_gh_tracker_pkg::*;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;

  // Reference model: in-flight checkpoints oldest-first, current history, head slot number.
  int   m_q[$];
  int   m_gh;
  int   m_head;

  ibtb_gh_tracker_if bus();

  ibtb_gh_tracker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(int g, pc38_t t);
    return ((g * 4) + int'(t % 4)) % 256;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int size;
    size = m_q.size();
    check_output({tag, ".gh"},    64'(bus.read_ibtb_gh),      64'(m_gh));
    check_output({tag, ".empty"}, 64'(bus.empty),             64'(size == 0));
    check_output({tag, ".ready"}, 64'(bus.predict_ready),     64'(size < 8));
    check_output({tag, ".idx"},   64'(bus.predict_chkpt_idx), 64'((m_head + size) % 8));
    if (size > 0) begin
      check_output({tag, ".cgh"}, 64'(bus.commit_ibtb_gh), 64'(m_q[0]));
    end
  endtask

  task automatic idle_inputs();
    bus.predict_valid     = 1'b0;
    bus.predict_tgt_pc38  = '0;
    bus.commit_valid      = 1'b0;
    bus.restore_valid     = 1'b0;
    bus.restore_chkpt_idx = '0;
    bus.restore_tgt_pc38  = '0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, check after.
  task automatic apply_stimulus(input string tag, input bit pv, input pc38_t ptgt, input bit cv,
                                input bit rv, input int ridx, input pc38_t rtgt);
    int size;
    int p;
    bus.predict_valid     = pv;
    bus.predict_tgt_pc38  = ptgt;
    bus.commit_valid      = cv;
    bus.restore_valid     = rv;
    bus.restore_chkpt_idx = ibtb_gh_chkpt_idx_t'(ridx);
    bus.restore_tgt_pc38  = rtgt;
    size = m_q.size();
    @(posedge clk);
    if (rv) begin
      p = (ridx - m_head + 8) % 8;
      m_gh = model_next(m_q[p], rtgt);
      while (m_q.size() > p + 1) void'(m_q.pop_back());
    end else if (pv && size < 8) begin
      m_q.push_back(m_gh);
      m_gh = model_next(m_gh, ptgt);
    end
    if (cv && size > 0) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % 8;
    end
    @(negedge clk);
    idle_inputs();
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    m_q.delete();
    m_gh   = 0;
    m_head = 0;
    repeat (2) @(negedge clk);
    check_state({tag, ".inrst"});
    rst_n = 1'b1;
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    int size;
    bit pv, cv, rv;
    int ridx;
    pc38_t ptgt, rtgt;

    err_cnt = 0;
    chk_cnt = 0;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset values.
    do_reset("reset");

    // Three pushes then three commits.
    apply_stimulus("push1", 1, 38'h1, 0, 0, 0, 0);
    check_output("push1.gh_lit", 64'(bus.read_ibtb_gh), 64'h01);
    apply_stimulus("push2", 1, 38'h2, 0, 0, 0, 0);
    check_output("push2.gh_lit", 64'(bus.read_ibtb_gh), 64'h06);
    apply_stimulus("push3", 1, 38'h3, 0, 0, 0, 0);
    check_output("push3.gh_lit", 64'(bus.read_ibtb_gh), 64'h1B);
    check_output("commit1.cgh_lit", 64'(bus.commit_ibtb_gh), 64'h00);
    apply_stimulus("commit1", 0, 0, 1, 0, 0, 0);
    check_output("commit2.cgh_lit", 64'(bus.commit_ibtb_gh), 64'h01);
    apply_stimulus("commit2", 0, 0, 1, 0, 0, 0);
    check_output("commit3.cgh_lit", 64'(bus.commit_ibtb_gh), 64'h06);
    apply_stimulus("commit3", 0, 0, 1, 0, 0, 0);
    check_output("commit3.empty_lit", 64'(bus.empty), 64'h1);

    // Fill the ring, drop a push while full, commit, then push into the wrapped slot.
    do_reset("fill.reset");
    for (int i = 0; i < 8; i++) apply_stimulus("fill", 1, pc38_t'(i + 5), 0, 0, 0, 0);
    check_output("fill.ready_lit", 64'(bus.predict_ready), 64'h0);
    apply_stimulus("fill.drop", 1, 38'h3, 0, 0, 0, 0);
    apply_stimulus("fill.commit_push", 1, 38'h2, 1, 0, 0, 0);
    check_output("fill.ready_after", 64'(bus.predict_ready), 64'h1);
    check_output("fill.wrap_idx", 64'(bus.predict_chkpt_idx), 64'h0);
    apply_stimulus("fill.wrap_push", 1, 38'h1, 0, 0, 0, 0);

    // Restore to idx 1 with a simultaneous push that must be dropped.
    do_reset("restore.reset");
    apply_stimulus("rst.p0", 1, 38'h1, 0, 0, 0, 0);
    apply_stimulus("rst.p1", 1, 38'h2, 0, 0, 0, 0);
    apply_stimulus("rst.p2", 1, 38'h3, 0, 0, 0, 0);
    apply_stimulus("rst.p3", 1, 38'h1, 0, 0, 0, 0);
    apply_stimulus("rst.restore", 1, 38'h3, 0, 1, 1, 38'h2);
    check_output("rst.gh_lit", 64'(bus.read_ibtb_gh), 64'h06);
    check_output("rst.tail_lit", 64'(bus.predict_chkpt_idx), 64'h2);

    // Restore the head entry while it commits: ring becomes empty at head+1.
    apply_stimulus("rsthead", 0, 0, 1, 1, 0, 38'h1);
    check_output("rsthead.empty_lit", 64'(bus.empty), 64'h1);
    check_output("rsthead.idx_lit", 64'(bus.predict_chkpt_idx), 64'h1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      size = m_q.size();
      pv   = ($urandom % 4) != 0;
      cv   = (size > 0) && (($urandom % 3) == 0);
      rv   = (size > 0) && (($urandom % 8) == 0);
      ridx = (size > 0) ? (m_head + int'($urandom_range(0, size - 1))) % 8 : 0;
      ptgt = pc38_t'({$urandom, $urandom});
      rtgt = pc38_t'({$urandom, $urandom});
      apply_stimulus("rand", pv, ptgt, cv, rv, ridx, rtgt);
    end

    // Asynchronous reset with five branches in flight.
    do_reset("async.pre");
    for (int i = 0; i < 5; i++) apply_stimulus("async.push", 1, pc38_t'(i + 1), 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async.gh",    64'(bus.read_ibtb_gh),      64'h00);
    check_output("async.empty", 64'(bus.empty),             64'h1);
    check_output("async.ready", 64'(bus.predict_ready),     64'h1);
    check_output("async.idx",   64'(bus.predict_chkpt_idx), 64'h0);
    do_reset("async.post");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
